// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter giving the fetch (F) and data (D) ports shared access to a single-ported memory with 1-cycle read latency.
// Build option: define ARB_ADDR_CHECK_EN to reject out-of-window or misaligned addresses (DEADBEEF response plus err pulse).
module imem_port_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h80020000,
  parameter int          MEM_BYTES   = 1024,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   f_req,
  input  logic [31:0]            f_addr,
  output logic                   f_gnt,
  output logic [31:0]            f_rdata,
  output logic                   f_rvalid,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [31:0]            d_addr,
  input  logic [31:0]            d_wdata,
  output logic                   d_gnt,
  output logic [31:0]            d_rdata,
  output logic                   d_rvalid,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [STALL_CNT_W-1:0] f_stall_cnt,
  output logic                   err
);

  // Handshake: each requester holds req and its payload stable until gnt (combinational, same cycle);
  // the matching rvalid pulses exactly one cycle after the grant, and a new grant may be issued that same cycle.

  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

  logic                   last_d;      // 1 = D was granted most recently
  logic                   grant_f;
  logic                   grant_d;
  logic                   grant_any;
  logic                   addr_illegal;
  logic                   addr_bad;
  logic [31:0]            gnt_addr;
  logic                   resp_valid;
  logic                   resp_f;
  logic                   resp_we;
  logic                   resp_err;
  logic [31:0]            resp_data;
  logic [31:0]            f_rdata_q;
  logic [31:0]            d_rdata_q;
  logic [STALL_CNT_W-1:0] stall_q;

  always_comb begin
    grant_f   = !reset && f_req && (!d_req || last_d);
    grant_d   = !reset && d_req && !grant_f;
    grant_any = grant_f || grant_d;
    gnt_addr  = grant_d ? d_addr : f_addr;
  end

  assign addr_illegal = ({1'b0, gnt_addr} < WIN_LO) || ({1'b0, gnt_addr} >= WIN_HI) ||
                        (gnt_addr[1:0] != 2'b00);

`ifdef ARB_ADDR_CHECK_EN
  assign addr_bad = grant_any && addr_illegal;
`else
  logic unused_addr_illegal;
  assign unused_addr_illegal = addr_illegal;
  assign addr_bad = 1'b0;
`endif

  always_comb begin
    f_gnt     = grant_f;
    d_gnt     = grant_d;
    mem_en    = grant_any && !addr_bad;
    mem_we    = grant_any && !addr_bad && grant_d && d_we;
    mem_addr  = gnt_addr;
    mem_wdata = grant_d ? d_wdata : 32'h0;
  end

  // Response stage: the winner sees rvalid next cycle, the other port keeps its last data.
  always_comb begin
    resp_data = resp_err ? 32'hDEADBEEF : (resp_we ? 32'h0 : mem_rdata);
    f_rvalid  = !reset && resp_valid && resp_f;
    d_rvalid  = !reset && resp_valid && !resp_f;
    err       = !reset && resp_valid && resp_err;
    f_rdata   = reset ? 32'h0 : (f_rvalid ? resp_data : f_rdata_q);
    d_rdata   = reset ? 32'h0 : (d_rvalid ? resp_data : d_rdata_q);
    f_stall_cnt = stall_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_d     <= 1'b1;
      resp_valid <= 1'b0;
      resp_f     <= 1'b0;
      resp_we    <= 1'b0;
      resp_err   <= 1'b0;
      f_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
      stall_q    <= '0;
    end else begin
      if (grant_any) last_d <= grant_d;
      resp_valid <= grant_any;
      resp_f     <= grant_f;
      resp_we    <= grant_d && d_we;
      resp_err   <= addr_bad;
      if (f_rvalid) f_rdata_q <= resp_data;
      if (d_rvalid) d_rdata_q <= resp_data;
      if (f_req && !grant_f && (stall_q != {STALL_CNT_W{1'b1}}))
        stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

endmodule
